// File: rtl/sd_spi_card_responder_if.sv
// SPI-mode SD link wires between the host (master) and the card model (slave).
`timescale 1ns / 1ps

interface sd_spi_card_responder_if;
    logic sd_cclk;  // SPI clock from host
    logic sd_cmd;   // MOSI, host -> card
    logic sd_cs;    // chip select, active low
    logic sd_data;  // MISO, card -> host

    modport master (
        output sd_cclk,
        output sd_cmd,
        output sd_cs,
        input  sd_data
    );

    modport slave (
        input  sd_cclk,
        input  sd_cmd,
        input  sd_cs,
        output sd_data
    );
endinterface

// File: rtl/sd_spi_card_responder.sv
// SD card (responder) end of an SPI-mode link. Oversamples the SPI wires with clk,
// decodes 48-bit command frames and answers with R1/R3/R7 responses, enough for the
// CMD0 -> CMD8 -> CMD55/ACMD41 -> CMD58 bring-up sequence.
`timescale 1ns / 1ps

module sd_spi_card_responder #(
    parameter int unsigned NCR_BYTES  = 1,
    parameter int unsigned INIT_POLLS = 2,
    parameter logic [31:0] OCR_VALUE  = 32'h40FF8000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sd_spi_card_responder_if.slave  spi,
    output logic                    cmd_valid,
    output logic [5:0]              cmd_index,
    output logic [31:0]             cmd_arg,
    output logic                    crc_error,
    output logic                    card_ready
);

    localparam int unsigned NcrBits   = 8 * NCR_BYTES;
    localparam logic [6:0]  NcrBitsW  = 7'(NcrBits);
    localparam logic [7:0]  InitPolls = 8'(INIT_POLLS);

    typedef enum logic [2:0] {
        StHunt,
        StRx,
        StDecode,
        StNcr,
        StTx
    } state_e;

    // CRC7, polynomial x^7 + x^3 + 1, MSB first, zero preset.
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) begin
                c = c ^ 7'h09;
            end
        end
        return c;
    endfunction

    // Synchronizer stages and previous cclk sample for edge detection.
    logic cclk_m, cclk_s, cclk_p;
    logic mosi_m, mosi_s;
    logic cs_m, cs_s;

    state_e      state_q, state_d;
    logic [47:0] sh_q, sh_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [39:0] resp_q, resp_d;
    logic [5:0]  resp_len_q, resp_len_d;
    logic        miso_q, miso_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [5:0]  cmd_index_q, cmd_index_d;
    logic [31:0] cmd_arg_q, cmd_arg_d;
    logic        crc_error_q, crc_error_d;
    logic        card_ready_q, card_ready_d;
    logic        in_idle_q, in_idle_d;
    logic        app_cmd_q, app_cmd_d;
    logic [7:0]  acmd41_cnt_q, acmd41_cnt_d;

    logic        cclk_rise, cclk_fall;
    logic [5:0]  dec_idx;
    logic [31:0] dec_arg;
    logic        dec_crc_ok;
    logic [7:0]  r1_idle;

    assign cclk_rise  = cclk_s & ~cclk_p;
    assign cclk_fall  = ~cclk_s & cclk_p;
    assign dec_idx    = sh_q[45:40];
    assign dec_arg    = sh_q[39:8];
    assign dec_crc_ok = (crc7(sh_q[47:8]) == sh_q[7:1]);
    assign r1_idle    = {7'b0, in_idle_q};

    // Two-flop synchronizers on all SPI inputs; cs resets deasserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cclk_m <= 1'b0;
            cclk_s <= 1'b0;
            cclk_p <= 1'b0;
            mosi_m <= 1'b1;
            mosi_s <= 1'b1;
            cs_m   <= 1'b1;
            cs_s   <= 1'b1;
        end else begin
            cclk_m <= spi.sd_cclk;
            cclk_s <= cclk_m;
            cclk_p <= cclk_s;
            mosi_m <= spi.sd_cmd;
            mosi_s <= mosi_m;
            cs_m   <= spi.sd_cs;
            cs_s   <= cs_m;
        end
    end

    // State register and all card/frame state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StHunt;
            sh_q         <= '0;
            cnt_q        <= '0;
            resp_q       <= '0;
            resp_len_q   <= '0;
            miso_q       <= 1'b1;
            cmd_valid_q  <= 1'b0;
            cmd_index_q  <= '0;
            cmd_arg_q    <= '0;
            crc_error_q  <= 1'b0;
            card_ready_q <= 1'b0;
            in_idle_q    <= 1'b1;
            app_cmd_q    <= 1'b0;
            acmd41_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            cnt_q        <= cnt_d;
            resp_q       <= resp_d;
            resp_len_q   <= resp_len_d;
            miso_q       <= miso_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_index_q  <= cmd_index_d;
            cmd_arg_q    <= cmd_arg_d;
            crc_error_q  <= crc_error_d;
            card_ready_q <= card_ready_d;
            in_idle_q    <= in_idle_d;
            app_cmd_q    <= app_cmd_d;
            acmd41_cnt_q <= acmd41_cnt_d;
        end
    end

    // Next-state: frame capture, command decode and response shifting.
    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        cnt_d        = cnt_q;
        resp_d       = resp_q;
        resp_len_d   = resp_len_q;
        miso_d       = miso_q;
        cmd_valid_d  = 1'b0;
        cmd_index_d  = cmd_index_q;
        cmd_arg_d    = cmd_arg_q;
        crc_error_d  = crc_error_q;
        card_ready_d = card_ready_q;
        in_idle_d    = in_idle_q;
        app_cmd_d    = app_cmd_q;
        acmd41_cnt_d = acmd41_cnt_q;

        if (cs_s) begin
            // Deselected: drop whatever was in flight, card state untouched.
            state_d = StHunt;
            miso_d  = 1'b1;
        end else begin
            unique case (state_q)
                StHunt: begin
                    miso_d = 1'b1;
                    if (cclk_rise && !mosi_s) begin
                        sh_d    = '0;
                        cnt_d   = 7'd1;
                        state_d = StRx;
                    end
                end

                StRx: begin
                    if (cclk_rise) begin
                        sh_d  = {sh_q[46:0], mosi_s};
                        cnt_d = cnt_q + 7'd1;
                        if (cnt_q == 7'd47) begin
                            // sh_q[45] becomes bit 46 (transmission bit); mosi is the end bit.
                            state_d = (sh_q[45] && mosi_s) ? StDecode : StHunt;
                        end
                    end
                end

                StDecode: begin
                    cmd_valid_d = 1'b1;
                    cmd_index_d = dec_idx;
                    cmd_arg_d   = dec_arg;
                    crc_error_d = ~dec_crc_ok;
                    app_cmd_d   = 1'b0;
                    resp_len_d  = 6'd8;
                    resp_d      = {r1_idle | 8'h04, 32'd0};
                    if (!dec_crc_ok && (dec_idx == 6'd0 || dec_idx == 6'd8)) begin
                        resp_d = {r1_idle | 8'h08, 32'd0};
                    end else begin
                        case (dec_idx)
                            6'd0: begin
                                in_idle_d    = 1'b1;
                                card_ready_d = 1'b0;
                                acmd41_cnt_d = '0;
                                resp_d       = {8'h01, 32'd0};
                            end
                            6'd8: begin
                                resp_len_d = 6'd40;
                                resp_d     = {r1_idle, 8'h00, 8'h00,
                                              {7'b0, dec_arg[11:8] == 4'b0001},
                                              dec_arg[7:0]};
                            end
                            6'd55: begin
                                app_cmd_d = 1'b1;
                                resp_d    = {r1_idle, 32'd0};
                            end
                            6'd41: begin
                                if (app_cmd_q) begin
                                    if (acmd41_cnt_q == InitPolls) begin
                                        in_idle_d    = 1'b0;
                                        card_ready_d = 1'b1;
                                        resp_d       = {8'h00, 32'd0};
                                    end else begin
                                        acmd41_cnt_d = acmd41_cnt_q + 8'd1;
                                        resp_d       = {8'h01, 32'd0};
                                    end
                                end
                            end
                            6'd58: begin
                                resp_len_d = 6'd40;
                                resp_d     = {r1_idle, ~in_idle_q, OCR_VALUE[30:0]};
                            end
                            default: ;
                        endcase
                    end
                    cnt_d   = '0;
                    state_d = StNcr;
                end

                StNcr: begin
                    if (cclk_fall) begin
                        if (cnt_q == NcrBitsW) begin
                            miso_d  = resp_q[39];
                            resp_d  = {resp_q[38:0], 1'b0};
                            cnt_d   = 7'd1;
                            state_d = StTx;
                        end else begin
                            miso_d = 1'b1;
                            cnt_d  = cnt_q + 7'd1;
                        end
                    end
                end

                StTx: begin
                    if (cclk_fall) begin
                        // Falling edge after the last bit: it has been held a full period.
                        if (cnt_q == {1'b0, resp_len_q}) begin
                            miso_d  = 1'b1;
                            state_d = StHunt;
                        end else begin
                            miso_d = resp_q[39];
                            resp_d = {resp_q[38:0], 1'b0};
                            cnt_d  = cnt_q + 7'd1;
                        end
                    end
                end

                default: begin
                    state_d = StHunt;
                    miso_d  = 1'b1;
                end
            endcase
        end
    end

    assign spi.sd_data = miso_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_index   = cmd_index_q;
    assign cmd_arg     = cmd_arg_q;
    assign crc_error   = crc_error_q;
    assign card_ready  = card_ready_q;

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Bench for sd_spi_card_responder: host-side SPI driver plus a card model that
// predicts responses and status from the command rules.
`timescale 1ns / 1ps

module tb_sd_spi_card_responder;

    localparam int unsigned NCR        = 2;
    localparam int unsigned POLLS      = 2;
    localparam logic [31:0] OCR        = 32'h40FF8000;
    localparam int unsigned HALF       = 4;  // clk cycles per half cclk period

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        crc_error;
    logic        card_ready;

    always #5 clk = ~clk;

    sd_spi_card_responder_if spi ();

    sd_spi_card_responder #(
        .NCR_BYTES  (NCR),
        .INIT_POLLS (POLLS),
        .OCR_VALUE  (OCR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi        (spi),
        .cmd_valid  (cmd_valid),
        .cmd_index  (cmd_index),
        .cmd_arg    (cmd_arg),
        .crc_error  (crc_error),
        .card_ready (card_ready)
    );

    int n_total = 0;
    int n_bad   = 0;
    int vcount  = 0;

    // Count cmd_valid cycles; a proper pulse adds exactly one per decoded frame.
    always @(negedge clk) begin
        if (cmd_valid === 1'b1) vcount++;
    end

    // Card model state.
    bit          m_idle  = 1'b1;
    bit          m_app   = 1'b0;
    int          m_polls = 0;
    logic [7:0]  exp_q[$];
    bit          exp_ok;
    logic [5:0]  e_idx;
    logic [31:0] e_arg;
    bit          e_crcerr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // CRC7 as the remainder of polynomial long division by 0x89 (x^7+x^3+1).
    function automatic logic [6:0] crc_div(input logic [39:0] d);
        logic [46:0] v;
        logic [46:0] p;
        v = {d, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (v[i]) begin
                p = 47'h89 << (i - 7);
                v = v ^ p;
            end
        end
        return v[6:0];
    endfunction

    function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg,
                                             input bit bad);
        logic [6:0] c;
        c = crc_div({2'b01, idx, arg});
        if (bad) c = c ^ 7'h01;
        return {2'b01, idx, arg, c, 1'b1};
    endfunction

    // Predict the response bytes and status for one frame, updating card state.
    task automatic model_frame(input logic [47:0] f);
        logic [7:0]  r1;
        logic [31:0] ocr;
        bit          app;
        exp_q.delete();
        exp_ok   = (f[47] == 1'b0) && (f[46] == 1'b1) && (f[0] == 1'b1);
        e_idx    = f[45:40];
        e_arg    = f[39:8];
        e_crcerr = (crc_div(f[47:8]) != f[7:1]);
        if (!exp_ok) return;
        r1    = m_idle ? 8'h01 : 8'h00;
        app   = m_app;
        m_app = 1'b0;
        if (e_crcerr && (e_idx == 6'd0 || e_idx == 6'd8)) begin
            exp_q.push_back(r1 | 8'h08);
        end else if (e_idx == 6'd0) begin
            m_idle  = 1'b1;
            m_polls = 0;
            exp_q.push_back(8'h01);
        end else if (e_idx == 6'd8) begin
            exp_q.push_back(r1);
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h00);
            exp_q.push_back((e_arg[11:8] == 4'h1) ? 8'h01 : 8'h00);
            exp_q.push_back(e_arg[7:0]);
        end else if (e_idx == 6'd55) begin
            m_app = 1'b1;
            exp_q.push_back(r1);
        end else if (e_idx == 6'd41 && app) begin
            if (m_polls == int'(POLLS)) begin
                m_idle = 1'b0;
                exp_q.push_back(8'h00);
            end else begin
                m_polls++;
                exp_q.push_back(8'h01);
            end
        end else if (e_idx == 6'd58) begin
            ocr = {~m_idle, OCR[30:0]};
            exp_q.push_back(r1);
            for (int k = 3; k >= 0; k--) exp_q.push_back(ocr[8*k +: 8]);
        end else begin
            exp_q.push_back(r1 | 8'h04);
        end
    endtask

    // One SPI mode-0 bit: present MOSI, rise (sample MISO), fall.
    task automatic spi_bit(input logic b, output logic r);
        spi.sd_cmd = b;
        repeat (HALF) @(negedge clk);
        spi.sd_cclk = 1'b1;
        r = spi.sd_data;
        repeat (HALF) @(negedge clk);
        spi.sd_cclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic [7:0] r;
        logic       b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], b);
            r[i] = b;
        end
        rx = r;
    endtask

    task automatic send_bytes(input logic [47:0] f);
        logic [7:0] rx;
        for (int k = 0; k < 6; k++) spi_byte(f[47-8*k -: 8], rx);
    endtask

    // Full transaction: send a frame, read NCR fill, response and one idle byte, check all.
    task automatic run_frame(input logic [47:0] f);
        logic [7:0] rx;
        int         v0;
        v0 = vcount;
        model_frame(f);
        send_bytes(f);
        for (int k = 0; k < int'(NCR); k++) begin
            spi_byte(8'hFF, rx);
            check_eq("ncr_fill", 64'(rx), 64'hFF);
        end
        foreach (exp_q[k]) begin
            spi_byte(8'hFF, rx);
            check_eq($sformatf("resp_cmd%0d_b%0d", e_idx, k), 64'(rx), 64'(exp_q[k]));
        end
        spi_byte(8'hFF, rx);
        check_eq("idle_after", 64'(rx), 64'hFF);
        repeat (4) @(negedge clk);
        check_eq("valid_pulses", 64'(vcount - v0), exp_ok ? 64'd1 : 64'd0);
        if (exp_ok) begin
            check_eq("cmd_index", 64'(cmd_index), 64'(e_idx));
            check_eq("cmd_arg", 64'(cmd_arg), 64'(e_arg));
            check_eq("crc_error", 64'(crc_error), 64'(e_crcerr));
        end
        check_eq("card_ready", 64'(card_ready), 64'(!m_idle));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rx;
        logic        b;
        int          v0;
        logic [5:0]  ridx;
        logic [31:0] rarg;
        logic [47:0] f;
        spi.sd_cclk = 1'b0;
        spi.sd_cmd  = 1'b1;
        spi.sd_cs   = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("rst_sd_data", 64'(spi.sd_data), 64'd1);
        check_eq("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check_eq("rst_cmd_index", 64'(cmd_index), 64'd0);
        check_eq("rst_cmd_arg", 64'(cmd_arg), 64'd0);
        check_eq("rst_crc_error", 64'(crc_error), 64'd0);
        check_eq("rst_card_ready", 64'(card_ready), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        spi.sd_cs = 1'b0;
        repeat (6) @(negedge clk);

        // Directed bring-up with literal frames.
        run_frame(48'h40_00000000_95);  // CMD0
        run_frame(48'h48_000001AA_87);  // CMD8
        run_frame(48'h40_00000000_97);  // CMD0, wrong CRC7 field
        run_frame(48'h51_00000000_FF);  // CMD17 while idle
        run_frame(48'h48_000001AA_86);  // end bit 0: dropped
        for (int r = 0; r < 3; r++) begin
            run_frame(48'h77_00000000_65);  // CMD55
            run_frame(48'h69_40000000_77);  // ACMD41
        end
        run_frame(48'h7A_00000000_FD);  // CMD58, ready

        // Deselect after 20 bits of a CMD8.
        v0 = vcount;
        f  = 48'h48_000001AA_87;
        for (int i = 47; i > 27; i--) spi_bit(f[i], b);
        spi.sd_cs = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("cs_abort_miso", 64'(spi.sd_data), 64'd1);
        spi_byte(8'h40, rx);
        check_eq("cs_high_ignored", 64'(rx), 64'hFF);
        check_eq("cs_abort_no_valid", 64'(vcount - v0), 64'd0);
        spi.sd_cs = 1'b0;
        repeat (6) @(negedge clk);
        run_frame(48'h40_00000000_95);  // CMD0 answered normally

        // Bring the card to ready, then reset in the middle of an R7.
        for (int r = 0; r < 3; r++) begin
            run_frame(48'h77_00000000_65);
            run_frame(48'h69_40000000_77);
        end
        f = 48'h48_000001AA_87;
        model_frame(f);
        send_bytes(f);
        for (int k = 0; k < int'(NCR); k++) spi_byte(8'hFF, rx);
        spi_byte(8'hFF, rx);
        check_eq("r7_b0_ready", 64'(rx), 64'h00);
        spi_byte(8'hFF, rx);
        check_eq("r7_b1", 64'(rx), 64'h00);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, b);
        repeat (4) @(negedge clk);
        check_eq("r7_mid_bit", 64'(spi.sd_data), 64'd0);
        check_eq("ready_before_rst", 64'(card_ready), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_sd_data", 64'(spi.sd_data), 64'd1);
        check_eq("rst_mid_ready", 64'(card_ready), 64'd0);
        m_idle  = 1'b1;
        m_app   = 1'b0;
        m_polls = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        run_frame(48'h7A_00000000_FD);  // busy OCR

        // Randomized command stream.
        for (int n = 0; n < 30; n++) begin
            rarg = $urandom;
            case ($urandom_range(0, 7))
                0: ridx = 6'd0;
                1: begin
                    ridx = 6'd8;
                    rarg = {20'h0, 4'($urandom_range(0, 2)), 8'($urandom)};
                end
                2: ridx = 6'd55;
                3: begin
                    ridx = 6'd41;
                    if ($urandom_range(0, 3) != 0) run_frame(mk_frame(6'd55, $urandom, 1'b0));
                end
                4: ridx = 6'd58;
                5: ridx = 6'd17;
                default: ridx = 6'($urandom);
            endcase
            f = mk_frame(ridx, rarg, $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) f[0] = 1'b0;
            run_frame(f);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
